fetch_unit: RTL and testbench

- IF stage plus IF/ID pipeline register for the 5-stage MIPS core; sits directly upstream of the hazard unit's decode/execute consumers.
- Owns the PC, issues one-at-a-time requests to a variable-latency instruction memory, and delivers instr_d/pcplus4_d to decode.
- Obeys stall_f/stall_d/flush_d and the pcsrc_e/pcbranch_e redirect from the hazard and execute logic.
- Inserts NOP bubbles (32'h0) when memory has not returned an instruction.

---
 rtl/mips_pkg.sv | 17 +
 rtl/ifid_reg.sv | 40 ++++
 rtl/fetch_unit.sv | 128 ++++++++++++
 tb/tb_fetch_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS core front end.
// The fetch FSM encoding and the NOP word live here so decode/hazard logic can share them.
package mips_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [XLEN_DEFAULT-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD,
        DISCARD
    } fetch_state_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load, and an idle cycle becomes a bubble.
// A bubble clears the instruction and valid but keeps pcplus4 from the last real instruction.
module ifid_reg
    import mips_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic            load,
    input  logic [XLEN-1:0] word,
    input  logic [XLEN-1:0] pcplus4,
    output logic [XLEN-1:0] instr_d,
    output logic [XLEN-1:0] pcplus4_d,
    output logic            valid_d
);

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_d   <= XLEN'(NOP_INSTR);
            pcplus4_d <= '0;
            valid_d   <= 1'b0;
        end else if (flush) begin
            instr_d <= XLEN'(NOP_INSTR);
            valid_d <= 1'b0;
        end else if (!stall) begin
            if (load) begin
                instr_d   <= word;
                pcplus4_d <= pcplus4;
                valid_d   <= 1'b1;
            end else begin
                instr_d <= XLEN'(NOP_INSTR);
                valid_d <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, runs a one-outstanding request FSM against instruction memory,
// and feeds the IF/ID register with delivered words or bubbles.
module fetch_unit
    import mips_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_f,
    input  logic            stall_d,
    input  logic            flush_d,
    input  logic            pcsrc_e,
    input  logic [XLEN-1:0] pcbranch_e,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] pc_f,
    output logic [XLEN-1:0] instr_d,
    output logic [XLEN-1:0] pcplus4_d,
    output logic            valid_d
);

    fetch_state_t    state_q, state_n;
    logic [XLEN-1:0] pc_q, pc_n;
    logic [XLEN-1:0] hold_q, hold_n;
    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] deliver_word;
    logic            deliver;
    logic            blocked;
    logic            accept;

    assign pc_inc    = pc_q + XLEN'(4);
    assign target    = pcbranch_e & ~XLEN'(3);
    assign blocked   = stall_d | stall_f;
    assign accept    = imem_req & imem_ready;
    assign imem_addr = pc_q;
    assign pc_f      = pc_q;

    always_comb begin
        state_n      = state_q;
        pc_n         = pc_q;
        hold_n       = hold_q;
        imem_req     = 1'b0;
        deliver      = 1'b0;
        deliver_word = hold_q;

        case (state_q)
            IDLE:    state_n = ISSUE;
            ISSUE: begin
                imem_req = 1'b1;
                if (accept) state_n = WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (!blocked) begin
                        deliver      = 1'b1;
                        deliver_word = imem_rdata;
                        state_n      = ISSUE;
                    end else begin
                        hold_n  = imem_rdata;
                        state_n = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!blocked) begin
                    deliver = 1'b1;
                    state_n = ISSUE;
                end
            end
            DISCARD: begin
                if (imem_rvalid) state_n = ISSUE;
            end
            default: state_n = IDLE;
        endcase

        if (deliver) pc_n = pc_inc;

        // A redirect kills any same-cycle delivery; an in-flight request must be drained in DISCARD.
        if (pcsrc_e && state_q != IDLE) begin
            deliver = 1'b0;
            pc_n    = target;
            case (state_q)
                ISSUE:   state_n = accept ? DISCARD : ISSUE;
                WAIT:    state_n = imem_rvalid ? ISSUE : DISCARD;
                HOLD:    state_n = ISSUE;
                DISCARD: state_n = imem_rvalid ? ISSUE : DISCARD;
                default: state_n = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
        end
    end

    // Parked word is only read in HOLD, which reset always leaves.
    always_ff @(posedge clk) begin
        hold_q <= hold_n;
    end

    ifid_reg #(
        .XLEN(XLEN)
    ) u_ifid (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall_d),
        .flush    (flush_d),
        .load     (deliver),
        .word     (deliver_word),
        .pcplus4  (pc_inc),
        .instr_d  (instr_d),
        .pcplus4_d(pcplus4_d),
        .valid_d  (valid_d)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a reactive memory plus a stream-level model of the
// expected instruction sequence, checked by a separate monitor against a scoreboard queue.
module tb_fetch_unit;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        stall_f, stall_d, flush_d, pcsrc_e;
    logic [31:0] pcbranch_e;
    logic        imem_req, imem_ready, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] pc_f, instr_d, pcplus4_d;
    logic        valid_d;

    fetch_unit #(
        .XLEN    (XLEN),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall_f    (stall_f),
        .stall_d    (stall_d),
        .flush_d    (flush_d),
        .pcsrc_e    (pcsrc_e),
        .pcbranch_e (pcbranch_e),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .pc_f       (pc_f),
        .instr_d    (instr_d),
        .pcplus4_d  (pcplus4_d),
        .valid_d    (valid_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        q[$];
    logic [31:0] next_push;

    int n_tests = 0;
    int n_fail  = 0;
    int deliveries = 0;
    int fired = 0;

    // Stimulus knobs, set by the main sequence and read by the driver.
    int          lat_min = 1, lat_max = 1;
    int          p_ready = 100, p_stall = 0, p_redir = 0;
    int          mode = 0;
    logic [31:0] mode_tgt = 32'h0;
    int          reset_cycles = 3;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic topup();
        while (q.size() < 4) begin
            q.push_back('{pc: next_push, instr: memf(next_push)});
            next_push = next_push + 32'd4;
        end
    endtask

    task automatic restart(input logic [31:0] a);
        q.delete();
        next_push = a & ~32'd3;
        topup();
    endtask

    // Driver and memory responder: everything changes on the falling edge.
    initial begin : driver
        int          since_reset;
        int          hold_stall;
        int          cnt;
        bit          pending;
        logic [31:0] paddr;
        since_reset = 0;
        hold_stall  = 0;
        cnt         = 0;
        pending     = 1'b0;
        paddr       = '0;
        reset       = 1'b1;
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        flush_d     = 1'b0;
        pcsrc_e     = 1'b0;
        pcbranch_e  = '0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        restart(RESET_PC);
        forever begin
            @(negedge clk);
            topup();
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (pending) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = memf(paddr);
                    pending     = 1'b0;
                end
            end

            if (reset_cycles > 0) begin
                reset = 1'b1;
                reset_cycles--;
            end else if (mode == 3 && pending && cnt == 2 && since_reset > 2) begin
                reset = 1'b1;
                mode  = 0;
                fired++;
            end else begin
                reset = 1'b0;
            end
            if (reset) begin
                since_reset = 0;
                restart(RESET_PC);
            end else begin
                since_reset++;
            end

            pcsrc_e = 1'b0;
            flush_d = 1'b0;
            if (!reset && since_reset > 2) begin
                if ((mode == 1 && pending && !imem_rvalid) || (mode == 2 && imem_rvalid)) begin
                    pcsrc_e    = 1'b1;
                    pcbranch_e = mode_tgt;
                    flush_d    = (mode == 2);
                    mode       = 0;
                    fired++;
                end else if (mode == 0 && $urandom_range(99) < p_redir) begin
                    pcsrc_e    = 1'b1;
                    pcbranch_e = $urandom;
                    flush_d    = 1'($urandom_range(1));
                end
                if (pcsrc_e) restart(pcbranch_e);
            end

            if (mode == 4 && imem_rvalid && !pcsrc_e && !reset) begin
                hold_stall = 2;
                mode       = 0;
                fired++;
            end
            if (hold_stall > 0) begin
                stall_d = 1'b1;
                stall_f = 1'b1;
                hold_stall--;
            end else begin
                stall_d = ($urandom_range(99) < p_stall);
                stall_f = ($urandom_range(99) < p_stall);
            end

            imem_ready = !pending && ($urandom_range(99) < p_ready);
            if (imem_req && imem_ready) begin
                if (!pcsrc_e && !reset) check("req_addr", 96'(imem_addr), 96'(q[0].pc));
                pending = 1'b1;
                paddr   = imem_addr;
                cnt     = $urandom_range(lat_max, lat_min);
            end
        end
    end

    // Monitor: models IF/ID and the PC at stream level, infers deliveries from valid_d.
    initial begin : monitor
        logic        s_reset, s_sd, s_sf, s_fl, s_pcs;
        logic [31:0] s_tgt;
        logic [31:0] exp_instr, exp_pc4, exp_pc;
        logic        exp_valid;
        int          idle;
        exp_t        e;
        exp_instr = '0;
        exp_pc4   = '0;
        exp_valid = 1'b0;
        exp_pc    = RESET_PC;
        idle      = 0;
        forever begin
            @(posedge clk);
            s_reset = reset;
            s_sd    = stall_d;
            s_sf    = stall_f;
            s_fl    = flush_d;
            s_pcs   = pcsrc_e;
            s_tgt   = pcbranch_e;
            #1;
            idle++;
            if (s_reset) begin
                exp_instr = '0;
                exp_pc4   = '0;
                exp_valid = 1'b0;
                exp_pc    = RESET_PC;
                check("rst_req", 96'(imem_req), 96'd0);
            end else begin
                if (s_fl) begin
                    exp_instr = '0;
                    exp_valid = 1'b0;
                end else if (!s_sd) begin
                    if (valid_d === 1'b1 && !s_sf && !s_pcs) begin
                        e         = q.pop_front();
                        exp_instr = e.instr;
                        exp_pc4   = e.pc + 32'd4;
                        exp_valid = 1'b1;
                        exp_pc    = e.pc + 32'd4;
                        deliveries++;
                        idle = 0;
                    end else begin
                        exp_instr = '0;
                        exp_valid = 1'b0;
                    end
                end
                if (s_pcs) exp_pc = s_tgt & ~32'd3;
            end
            check("ifid", {31'd0, valid_d, instr_d, pcplus4_d}, {31'd0, exp_valid, exp_instr, exp_pc4});
            check("pc_f", 96'(pc_f), 96'(exp_pc));
            if (idle > 400) begin
                n_tests++;
                n_fail++;
                $display("FAIL progress: no delivery for %0d cycles at %0t", idle, $time);
                idle = 0;
            end
        end
    end

    task automatic run_mode(input int m, input logic [31:0] t);
        mode_tgt = t;
        mode     = m;
        for (int i = 0; i < 300 && mode != 0; i++) @(posedge clk);
        if (mode != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL mode%0d: trigger never seen, still %0d, required 0", m, mode);
            mode = 0;
        end
    endtask

    initial begin : main
        repeat (40) @(posedge clk);
        lat_min = 3; lat_max = 3;
        repeat (40) @(posedge clk);
        lat_min = 1; lat_max = 2;
        run_mode(4, 32'h0);
        repeat (20) @(posedge clk);
        lat_min = 3; lat_max = 3;
        run_mode(1, 32'h0000_0043);
        repeat (20) @(posedge clk);
        lat_min = 2; lat_max = 2;
        run_mode(2, $urandom);
        repeat (20) @(posedge clk);
        lat_min = 3; lat_max = 3;
        run_mode(1, 32'hFFFF_FFFC);
        lat_min = 1; lat_max = 1;
        repeat (20) @(posedge clk);
        lat_min = 3; lat_max = 3;
        run_mode(3, 32'h0);
        repeat (30) @(posedge clk);
        lat_min = 1; lat_max = 4;
        p_ready = 70; p_stall = 25; p_redir = 3;
        repeat (3000) @(posedge clk);
        p_stall = 0; p_redir = 0; p_ready = 100;
        repeat (50) @(posedge clk);
        check("deliveries_min", 96'(deliveries >= 200), 96'd1);
        check("oneshots_fired", 96'(fired), 96'd5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
